io_router: RTL and testbench

- Parametrised successor to the fixed-map I/O decoder.
- Routes CPU I/O bus accesses to NSLAVE peripherals using per-slave base/mask address windows.
- Adds a wait-state handshake with per-access timeout, bus-error reporting, and a maskable, latched interrupt aggregator.
- Sits between the CPU I/O bus and the uart/spi/lcd/switch peripherals; owns a 4-word control register window of its own.

---
 rtl/io_router_if.sv | 24 ++
 rtl/io_router.sv | 198 +++++++++++++++++++
 tb/tb_io_router.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_router_if.sv
// CPU-side I/O bus between the processor and io_router.
// The master modport is the CPU side; the slave modport is the router side.
interface io_router_if #(
  parameter int AW = 11
);
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [3:0]    be;
  logic [31:0]   data_out;
  logic          ack;
  logic          bus_err;

  modport master (
    output read, write, address, data_in, be,
    input  data_out, ack, bus_err
  );

  modport slave (
    input  read, write, address, data_in, be,
    output data_out, ack, bus_err
  );
endinterface

// File: rtl/io_router.sv
// I/O router: base/mask window decode to NSLAVE peripherals with wait-state
// handshake, access timeout, bus-error capture and a latched interrupt aggregator.
module io_router #(
  parameter int                     NSLAVE    = 8,
  parameter int                     AW        = 11,
  parameter logic [NSLAVE*AW-1:0]   BASE      = {NSLAVE{AW'(0)}},
  parameter logic [NSLAVE*AW-1:0]   MASK      = {NSLAVE{AW'(11'h7F8)}},
  parameter logic [AW-1:0]          CTRL_BASE = AW'(11'h7F0),
  parameter int                     TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_router_if.slave            bus,
  output logic [NSLAVE-1:0]     s_read,
  output logic [NSLAVE-1:0]     s_write,
  output logic [AW-1:0]         s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_be,
  input  logic [32*NSLAVE-1:0]  s_readdata,
  input  logic [NSLAVE-1:0]     s_ack,
  input  logic [NSLAVE-1:0]     s_irq,
  output logic                  interrupt
);

  localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t            r_state;
  logic [31:0]       r_data_out;
  logic              r_ack;
  logic              r_bus_err;
  logic [NSLAVE-1:0] r_s_read;
  logic [NSLAVE-1:0] r_s_write;
  logic [AW-1:0]     r_s_addr;
  logic [31:0]       r_s_wdata;
  logic [3:0]        r_s_be;
  logic              r_is_read;
  logic [15:0]       r_cnt;
  logic [NSLAVE-1:0] r_mask;
  logic [NSLAVE-1:0] r_pending;
  logic [NSLAVE-1:0] r_irq_prev;
  logic [AW-1:0]     r_err_addr;
  logic              r_err_sticky;
  logic              r_interrupt;

  logic              w_req;
  logic              w_ctrl_hit;
  logic              w_slave_hit;
  logic [SW-1:0]     w_sel;
  logic [31:0]       w_bem;
  logic [31:0]       w_ctrl_rdata;
  logic [31:0]       w_rdata_sel;
  logic              w_ack_sel;
  logic              w_pend_wr;
  logic [NSLAVE-1:0] w_pend_clr;
  logic [NSLAVE-1:0] w_irq_rise;
  logic [NSLAVE-1:0] w_strobe;

  assign w_req      = bus.read | bus.write;
  assign w_ctrl_hit = (bus.address & ~AW'(4'hF)) == CTRL_BASE;
  assign w_bem      = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  assign w_strobe   = r_s_read | r_s_write;
  // The strobe is one-hot, so it doubles as the select for ack and read data.
  assign w_ack_sel  = |(s_ack & w_strobe);
  assign w_irq_rise = s_irq & ~r_irq_prev;
  assign w_pend_wr  = (r_state == ST_IDLE) && bus.write && !bus.read && w_ctrl_hit &&
                      (bus.address[3:2] == 2'd0);
  assign w_pend_clr = w_pend_wr ? (bus.data_in[NSLAVE-1:0] & w_bem[NSLAVE-1:0]) : '0;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_slave_hit = 1'b0;
    w_sel       = '0;
    w_rdata_sel = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (!w_slave_hit && ((bus.address & MASK[AW*i +: AW]) == BASE[AW*i +: AW])) begin
        w_slave_hit = 1'b1;
        w_sel       = SW'(i);
      end
      w_rdata_sel = w_rdata_sel | (s_readdata[32*i +: 32] & {32{w_strobe[i]}});
    end
  end

  always_comb begin
    w_ctrl_rdata = '0;
    case (bus.address[3:2])
      2'd0:    w_ctrl_rdata = 32'(r_pending);
      2'd1:    w_ctrl_rdata = 32'(r_mask);
      2'd2:    w_ctrl_rdata = 32'(r_err_addr);
      default: w_ctrl_rdata = {31'b0, r_err_sticky};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_data_out   <= '0;
      r_ack        <= 1'b0;
      r_bus_err    <= 1'b0;
      r_s_read     <= '0;
      r_s_write    <= '0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_be       <= '0;
      r_is_read    <= 1'b0;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_irq_prev   <= '0;
      r_err_addr   <= '0;
      r_err_sticky <= 1'b0;
      r_interrupt  <= 1'b0;
    end else begin
      r_irq_prev  <= s_irq;
      r_interrupt <= |(r_pending & r_mask);
      // A new edge beats a simultaneous write-1-to-clear.
      r_pending   <= (r_pending & ~w_pend_clr) | w_irq_rise;

      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_s_addr  <= bus.address;
            r_s_wdata <= bus.data_in;
            r_s_be    <= bus.be;
            r_is_read <= bus.read;
            if (w_ctrl_hit) begin
              r_ack      <= 1'b1;
              r_state    <= ST_DONE;
              r_data_out <= bus.read ? w_ctrl_rdata : '0;
              if (!bus.read) begin
                case (bus.address[3:2])
                  2'd1: r_mask <= (r_mask & ~w_bem[NSLAVE-1:0]) |
                                  (bus.data_in[NSLAVE-1:0] & w_bem[NSLAVE-1:0]);
                  2'd3: if (bus.be[0] && bus.data_in[0]) r_err_sticky <= 1'b0;
                  default: ;
                endcase
              end
            end else if (w_slave_hit) begin
              r_cnt   <= '0;
              r_state <= ST_ACCESS;
              if (bus.read) r_s_read  <= NSLAVE'(1) << w_sel;
              else          r_s_write <= NSLAVE'(1) << w_sel;
            end else begin
              r_ack        <= 1'b1;
              r_bus_err    <= 1'b1;
              r_data_out   <= '0;
              r_err_addr   <= bus.address;
              r_err_sticky <= 1'b1;
              r_state      <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          if (w_ack_sel) begin
            r_data_out <= r_is_read ? w_rdata_sel : '0;
            r_s_read   <= '0;
            r_s_write  <= '0;
            r_ack      <= 1'b1;
            r_state    <= ST_DONE;
          end else if (r_cnt == 16'(TIMEOUT - 1)) begin
            r_data_out   <= '0;
            r_s_read     <= '0;
            r_s_write    <= '0;
            r_ack        <= 1'b1;
            r_bus_err    <= 1'b1;
            r_err_addr   <= r_s_addr;
            r_err_sticky <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        ST_DONE: begin
          r_ack     <= 1'b0;
          r_bus_err <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.ack      = r_ack;
  assign bus.bus_err  = r_bus_err;
  assign s_read       = r_s_read;
  assign s_write      = r_s_write;
  assign s_addr       = r_s_addr;
  assign s_wdata      = r_s_wdata;
  assign s_be         = r_s_be;
  assign interrupt    = r_interrupt;

endmodule

// File: tb/tb_io_router.sv
// Directed bench for io_router: decode, wait states, timeout, bus errors,
// control registers, interrupt edge latching and mid-access reset.
module tb_io_router;

  localparam int NS = 8;
  localparam int AW = 11;
  // Slave 3 (0x100-0x10F) and slave 5 (0x100-0x107) overlap.
  localparam logic [NS*AW-1:0] BASE = {11'h030, 11'h028, 11'h100, 11'h020,
                                       11'h100, 11'h010, 11'h008, 11'h000};
  localparam logic [NS*AW-1:0] MASK = {11'h7F8, 11'h7F8, 11'h7F8, 11'h7F8,
                                       11'h7F0, 11'h7F8, 11'h7F8, 11'h7F8};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     s_read, s_write, s_ack, s_irq;
  logic [AW-1:0]     s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_be;
  logic [32*NS-1:0]  s_readdata;
  logic              interrupt;

  io_router_if #(.AW(AW)) bus ();

  io_router #(
    .NSLAVE(NS), .AW(AW), .BASE(BASE), .MASK(MASK),
    .CTRL_BASE(11'h7F0), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_be(s_be), .s_readdata(s_readdata), .s_ack(s_ack), .s_irq(s_irq),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave responder: acks on the resp_delay-th strobe cycle; 0 means never.
  int resp_delay = 1;
  int resp_cnt   = 0;
  always begin
    @(posedge clk);
    #1;
    if ((s_read | s_write) != '0) begin
      resp_cnt++;
      s_ack = (resp_delay != 0 && resp_cnt == resp_delay) ? (s_read | s_write) : '0;
    end else begin
      resp_cnt = 0;
      s_ack    = '0;
    end
  end

  logic [NS-1:0] obs_rd, obs_wr;
  int            obs_cycles;
  logic          obs_multi;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_wdata;
  logic [3:0]    obs_be;

  logic [31:0]   rdata;
  logic          err;
  int            lat;

  task automatic cpu_access(input logic rd, input logic [AW-1:0] a, input logic [31:0] wd,
                            input logic [3:0] b, output logic [31:0] data_o,
                            output logic err_o, output int lat_o);
    logic done;
    done = 1'b0; data_o = '0; err_o = 1'b0; lat_o = 0;
    obs_rd = '0; obs_wr = '0; obs_cycles = 0; obs_multi = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0;
    bus.read = rd; bus.write = ~rd; bus.address = a; bus.data_in = wd; bus.be = b;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      lat_o++;
      if ((s_read | s_write) != '0) begin
        obs_cycles++;
        obs_rd = obs_rd | s_read;
        obs_wr = obs_wr | s_write;
        if ($countones(s_read | s_write) > 1) obs_multi = 1'b1;
        obs_addr = s_addr; obs_wdata = s_wdata; obs_be = s_be;
      end
      if (bus.ack) begin
        done = 1'b1; data_o = bus.data_out; err_o = bus.bus_err;
      end
    end
    bus.read = 1'b0; bus.write = 1'b0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL ack_wait: no ack within 40 cycles, addr %h", a); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus.ack); end
    n_checks++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.bus_err); end
    n_checks++; if ((s_read | s_write) !== '0) begin n_fail++; $display("FAIL rst_strobe: rd %h wr %h want 0", s_read, s_write); end
    n_checks++; if ({s_addr, s_wdata, s_be} !== '0) begin n_fail++; $display("FAIL rst_latch: addr %h wdata %h be %h want 0", s_addr, s_wdata, s_be); end
    n_checks++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.data_out); end
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_min_latency();
    resp_delay = 1;
    cpu_access(1'b1, 11'h004, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL min_lat: got %0d want 2", lat); end
    n_checks++; if (rdata !== 32'hA000_0000) begin n_fail++; $display("FAIL min_data: got %h want a0000000", rdata); end
    n_checks++; if (obs_rd !== 8'h01 || obs_cycles !== 1) begin n_fail++; $display("FAIL min_strobe: rd %h cycles %0d want 01/1", obs_rd, obs_cycles); end
  endtask

  task automatic test_slave_read();
    resp_delay = 3;
    cpu_access(1'b1, 11'h00C, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (obs_rd !== 8'h02 || obs_wr !== 8'h00) begin n_fail++; $display("FAIL rd_strobe: rd %h wr %h want 02/00", obs_rd, obs_wr); end
    n_checks++; if (obs_cycles !== 3) begin n_fail++; $display("FAIL rd_wait: got %0d cycles want 3", obs_cycles); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd_lat: got %0d want 4", lat); end
    n_checks++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got %h want 12345678", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", err); end
  endtask

  task automatic test_unmapped();
    cpu_access(1'b0, 11'h300, 32'h0000_0055, 4'hF, rdata, err, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL um_lat: got %0d want 1", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL um_err: got %b want 1", err); end
    n_checks++; if (obs_cycles !== 0) begin n_fail++; $display("FAIL um_strobe: got %0d strobe cycles want 0", obs_cycles); end
    cpu_access(1'b1, 11'h7F8, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h300) begin n_fail++; $display("FAIL um_erraddr: got %h want 300", rdata); end
    n_checks++; if (lat !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL ctrl_lat: lat %0d err %b want 1/0", lat, err); end
    cpu_access(1'b1, 11'h7FC, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL um_status: got %h want 1", rdata); end
    cpu_access(1'b0, 11'h7FC, 32'h1, 4'h1, rdata, err, lat);
    cpu_access(1'b1, 11'h7FC, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL status_w1c: got %h want 0", rdata); end
  endtask

  task automatic test_timeout();
    resp_delay = 0;
    cpu_access(1'b1, 11'h010, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (obs_cycles !== 4 || obs_rd !== 8'h04) begin n_fail++; $display("FAIL to_strobe: cycles %0d rd %h want 4/04", obs_cycles, obs_rd); end
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL to_err: err %b data %h want 1/0", err, rdata); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL to_lat: got %0d want 5", lat); end
    resp_delay = 1;
    cpu_access(1'b1, 11'h7F8, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h010) begin n_fail++; $display("FAIL to_erraddr: got %h want 010", rdata); end
  endtask

  task automatic test_overlap();
    resp_delay = 1;
    cpu_access(1'b0, 11'h104, 32'hDEAD_BEEF, 4'b0110, rdata, err, lat);
    n_checks++; if (obs_wr !== 8'h08 || obs_rd !== 8'h00 || obs_multi !== 1'b0) begin n_fail++; $display("FAIL ov_strobe: wr %h rd %h multi %b want 08/00/0", obs_wr, obs_rd, obs_multi); end
    n_checks++; if ({obs_addr, obs_wdata, obs_be} !== {11'h104, 32'hDEAD_BEEF, 4'b0110}) begin n_fail++; $display("FAIL ov_latch: addr %h wdata %h be %b want 104/deadbeef/0110", obs_addr, obs_wdata, obs_be); end
    n_checks++; if (err !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL ov_ack: err %b lat %0d want 0/2", err, lat); end
  endtask

  task automatic test_mask_reg();
    cpu_access(1'b0, 11'h7F4, 32'hFFFF_FFFF, 4'hF, rdata, err, lat);
    cpu_access(1'b1, 11'h7F4, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'hFF) begin n_fail++; $display("FAIL mask_width: got %h want ff", rdata); end
    cpu_access(1'b0, 11'h7F4, 32'h0, 4'b0010, rdata, err, lat);
    cpu_access(1'b1, 11'h7F4, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'hFF) begin n_fail++; $display("FAIL mask_be_off: got %h want ff", rdata); end
    cpu_access(1'b0, 11'h7F4, 32'h04, 4'b0001, rdata, err, lat);
    cpu_access(1'b1, 11'h7F4, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h04) begin n_fail++; $display("FAIL mask_be_on: got %h want 04", rdata); end
  endtask

  task automatic test_interrupt();
    @(posedge clk); #1;
    s_irq[2] = 1'b1;
    @(posedge clk); #1;
    s_irq[2] = 1'b0;
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", interrupt); end
    @(posedge clk); #1;
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", interrupt); end
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h04) begin n_fail++; $display("FAIL irq_pend: got %h want 04", rdata); end
    cpu_access(1'b0, 11'h7F0, 32'h04, 4'hF, rdata, err, lat);
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", interrupt); end
    // Masked source latches pending but does not interrupt.
    s_irq[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_irq[3] = 1'b0;
    n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", interrupt); end
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h08) begin n_fail++; $display("FAIL irq_masked_pend: got %h want 08", rdata); end
    cpu_access(1'b0, 11'h7F0, 32'h08, 4'hF, rdata, err, lat);
    // Level held across W1C: edge-triggered, so stays clear.
    s_irq[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_hold_rise: got %b want 1", interrupt); end
    cpu_access(1'b0, 11'h7F0, 32'h04, 4'hF, rdata, err, lat);
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h0 || interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_hold_w1c: pend %h irq %b want 0/0", rdata, interrupt); end
    s_irq[2] = 1'b0;
    @(posedge clk); #1;
    // W1C outside the enabled byte leaves pending alone; new edge beats same-cycle W1C.
    s_irq[2] = 1'b1;
    cpu_access(1'b0, 11'h7F0, 32'h04, 4'hF, rdata, err, lat);
    cpu_access(1'b0, 11'h7F0, 32'h04, 4'b1110, rdata, err, lat);
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h04) begin n_fail++; $display("FAIL irq_set_wins: got %h want 04", rdata); end
    s_irq[2] = 1'b0;
    cpu_access(1'b0, 11'h7F0, 32'h04, 4'h1, rdata, err, lat);
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL irq_final_clear: got %h want 0", rdata); end
  endtask

  task automatic test_reset_mid_access();
    logic saw_ack;
    saw_ack = 1'b0;
    s_irq[5] = 1'b1;
    @(posedge clk); #1;
    s_irq[5] = 1'b0;
    resp_delay = 0;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 11'h00C; bus.be = 4'hF;
    @(posedge clk); #1;
    n_checks++; if (s_read !== 8'h02) begin n_fail++; $display("FAIL mr_strobe: got %h want 02", s_read); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (s_read !== 8'h00 || bus.ack !== 1'b0) begin n_fail++; $display("FAIL mr_drop: rd %h ack %b want 00/0", s_read, bus.ack); end
    bus.read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.ack) saw_ack = 1'b1;
    end
    n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL mr_no_ack: got ack %b want 0", saw_ack); end
    resp_delay = 1;
    cpu_access(1'b1, 11'h7F4, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mr_mask: got %h want 0", rdata); end
    cpu_access(1'b1, 11'h7F0, 32'h0, 4'hF, rdata, err, lat);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mr_pend: got %h want 0", rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_in = '0; bus.be = '0;
    s_irq = '0;
    s_ack = '0;
    for (int i = 0; i < NS; i++) s_readdata[32*i +: 32] = 32'hA000_0000 | 32'(i);
    s_readdata[32*1 +: 32] = 32'h1234_5678;

    test_reset();
    test_min_latency();
    test_slave_read();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_mask_reg();
    test_interrupt();
    test_reset_mid_access();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
